alu_muldiv: RTL
===============

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, operand/result width (even, >= 8).
REQ-002 The block SHALL have parameter MODE_WIDTH, default 6, opcode width.
REQ-003 The block SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port i_valid  input  1  request strobe, sampled with i_A/i_B/i_mode.
REQ-006 The block SHALL have port o_ready  output  1  block can accept a request this cycle.
REQ-007 The block SHALL have ports i_A, i_B  input  DATA_WIDTH  operands, unsigned unless op is signed.
REQ-008 The block SHALL have port i_mode  input  MODE_WIDTH  operation select.
REQ-009 The block SHALL have port o_valid  output  1  one-cycle pulse, o_result valid.
REQ-010 The block SHALL have port o_result  output  DATA_WIDTH  registered result.
REQ-011 The block SHALL have port o_zero  output  1  high when o_result == 0, held with o_result.
REQ-012 The block SHALL have port o_div_by_zero  output  1  high with o_valid of a DIV/DIVU whose i_B was 0.

Function
REQ-013 Accept on i_valid && o_ready only; i_valid while o_ready low SHALL be ignored, with no queuing.
REQ-014 Single-cycle ops SHALL register the result and pulse o_valid on the edge after acceptance: ADD 100000 (signed) and ADDU 100001, SUB 100010 and SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101000 (signed) and SLTU 101001 (result 1/0 zero-extended), SLL 000000, SRL 000010, SRA 000011.
REQ-015 Add/sub SHALL wrap modulo 2^DATA_WIDTH, no overflow flag.
REQ-016 Shift amount SHALL be i_B[$clog2(DATA_WIDTH)-1:0]; upper i_B bits are ignored.
REQ-017 Internal HI, LO registers, each DATA_WIDTH wide. MFHI 010000 and MFLO 010010 SHALL return HI/LO. MTHI 010001 and MTLO 010011 SHALL write i_A into HI/LO with o_result = i_A. All four take 1 cycle.
REQ-018 MULT 011000 (signed) and MULTU 011001 SHALL compute the 2*DATA_WIDTH product by iterative shift-add on magnitudes, one bit per cycle, with sign correction at the end; {HI,LO} = product.
REQ-019 DIV 011010 (signed) and DIVU 011011 SHALL use restoring division on magnitudes, one bit per cycle. LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
REQ-020 The FSM SHALL have states IDLE, MUL, DIV. IDLE->MUL/DIV on acceptance of a mul/div op. MUL/DIV->IDLE after DATA_WIDTH iteration cycles.
REQ-021 o_ready SHALL be high in IDLE and low in MUL/DIV.
REQ-022 Mul/div latency SHALL be DATA_WIDTH+1 edges from acceptance to o_valid.
REQ-023 In the o_valid cycle of a mul/div, o_ready SHALL be high, so back-to-back acceptance is allowed.
REQ-024 Mul/div o_result SHALL be the new LO. HI/LO SHALL update in the same edge that raises o_valid, never before.
REQ-025 DIV/DIVU with i_B == 0 SHALL still take full latency, with LO = all ones, HI = i_A, o_div_by_zero = 1.
REQ-026 Signed DIV of most-negative by -1 SHALL give LO = most-negative, HI = 0.
REQ-027 Undefined i_mode SHALL produce a 1-cycle result of all ones, with o_valid pulsed and HI/LO unchanged.
REQ-028 o_result/o_zero SHALL hold their last value between o_valid pulses. o_div_by_zero SHALL clear on the next accepted op.

Reset
REQ-029 While i_rst_n is low, regardless of clock: state=IDLE, o_ready=1, o_valid=0, o_result=0, o_zero=1, o_div_by_zero=0, HI=LO=0, iteration counter=0.
REQ-030 Reset asserted mid-MUL/DIV SHALL abort the operation with no o_valid and no HI/LO update. The first accept SHALL be possible on the first edge after deassertion.

Verification (DATA_WIDTH=8)
REQ-031 ADD A=0x7F B=0x01 -> next edge o_valid=1, o_result=0x80, o_zero=0. Then SUB 0x80-0x80 -> o_result=0x00, o_zero=1.
REQ-032 MULT A=0xFD(-3) B=0x05 -> o_ready low 8 cycles, o_valid on the 9th edge, o_result=0xF1. MFHI -> 0xFF; MFLO -> 0xF1.
REQ-033 DIV A=0x07 B=0xFE(-2) -> LO=0xFD, HI=0x01. DIVU 0xFF/0x10 -> LO=0x0F, HI=0x0F. DIV 0x80/0xFF -> LO=0x80, HI=0x00.
REQ-034 DIVU A=0x2A B=0x00 -> after 9 edges o_result=0xFF, o_div_by_zero=1, MFHI -> 0x2A.
REQ-035 Start DIV, pulse i_valid with ADD at cycle 3, then assert i_rst_n=0 at cycle 5 -> ADD ignored, no o_valid, MFHI/MFLO after reset -> 0x00.
REQ-036 MULTU 0xFF*0xFF, then issue ADDU 1+1 in the o_valid cycle -> {HI,LO}=0xFE01, and ADDU result 0x02 on the next edge.

Source files
------------

// File: rtl/alu_muldiv_if.sv
// Request/response bundle for alu_muldiv.
// Ports: request i_valid/i_A/i_B/i_mode with o_ready for acceptance.
//        Response o_valid pulse with o_result, o_zero and o_div_by_zero.
interface alu_muldiv_if #(
  parameter int DATA_WIDTH = 32,
  parameter int MODE_WIDTH = 6
);
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] i_A;
  logic [DATA_WIDTH-1:0] i_B;
  logic [MODE_WIDTH-1:0] i_mode;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_result;
  logic                  o_zero;
  logic                  o_div_by_zero;

  modport master (
    output i_valid, i_A, i_B, i_mode,
    input  o_ready, o_valid, o_result, o_zero, o_div_by_zero
  );

  modport slave (
    input  i_valid, i_A, i_B, i_mode,
    output o_ready, o_valid, o_result, o_zero, o_div_by_zero
  );
endinterface

// File: rtl/alu_muldiv.sv
// MIPS-style ALU with HI/LO registers and iterative multiply/divide.
// Latency: single-cycle ops 1 edge; MULT/MULTU/DIV/DIVU DATA_WIDTH+1 edges.
// Backpressure: o_ready low while mul/div iterates; requests then are dropped.
// Ports: i_clk, i_rst_n (async active-low), bus (alu_muldiv_if.slave).
module alu_muldiv #(
  parameter int DATA_WIDTH = 32,
  parameter int MODE_WIDTH = 6
) (
  input logic         i_clk,
  input logic         i_rst_n,
  alu_muldiv_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(DATA_WIDTH);
  typedef logic [MODE_WIDTH-1:0] mode_t;

  localparam mode_t OP_SLL   = mode_t'(6'b000000);
  localparam mode_t OP_SRL   = mode_t'(6'b000010);
  localparam mode_t OP_SRA   = mode_t'(6'b000011);
  localparam mode_t OP_MFHI  = mode_t'(6'b010000);
  localparam mode_t OP_MTHI  = mode_t'(6'b010001);
  localparam mode_t OP_MFLO  = mode_t'(6'b010010);
  localparam mode_t OP_MTLO  = mode_t'(6'b010011);
  localparam mode_t OP_MULT  = mode_t'(6'b011000);
  localparam mode_t OP_MULTU = mode_t'(6'b011001);
  localparam mode_t OP_DIV   = mode_t'(6'b011010);
  localparam mode_t OP_DIVU  = mode_t'(6'b011011);
  localparam mode_t OP_ADD   = mode_t'(6'b100000);
  localparam mode_t OP_ADDU  = mode_t'(6'b100001);
  localparam mode_t OP_SUB   = mode_t'(6'b100010);
  localparam mode_t OP_SUBU  = mode_t'(6'b100011);
  localparam mode_t OP_AND   = mode_t'(6'b100100);
  localparam mode_t OP_OR    = mode_t'(6'b100101);
  localparam mode_t OP_XOR   = mode_t'(6'b100110);
  localparam mode_t OP_NOR   = mode_t'(6'b100111);
  localparam mode_t OP_SLT   = mode_t'(6'b101000);
  localparam mode_t OP_SLTU  = mode_t'(6'b101001);
  localparam logic [SW-1:0] LAST_CNT = SW'(W - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state, state_nxt;

  logic [W-1:0]  hi, lo, result_q, acc_hi, acc_lo, opnd, a_save;
  logic          valid_q, zero_q, dbz_q, dbz, neg_hi, neg_lo;
  logic [SW-1:0] cnt;

  logic [W-1:0]  a, b, alu_res, a_mag, b_mag;
  logic [SW-1:0] shamt;
  logic          accept, is_mul, is_div, is_sgn, a_neg, b_neg, last;

  assign a      = bus.i_A;
  assign b      = bus.i_B;
  assign shamt  = b[SW-1:0];
  assign accept = bus.i_valid && bus.o_ready;
  assign last   = (cnt == LAST_CNT);

  assign bus.o_ready       = (state == IDLE);
  assign bus.o_valid       = valid_q;
  assign bus.o_result      = result_q;
  assign bus.o_zero        = zero_q;
  assign bus.o_div_by_zero = dbz_q;

  // Decode; anything not listed yields all ones and leaves HI/LO alone.
  always_comb begin
    alu_res = '1;
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_sgn  = 1'b0;
    case (bus.i_mode)
      OP_ADD, OP_ADDU: alu_res = a + b;
      OP_SUB, OP_SUBU: alu_res = a - b;
      OP_AND:          alu_res = a & b;
      OP_OR:           alu_res = a | b;
      OP_XOR:          alu_res = a ^ b;
      OP_NOR:          alu_res = ~(a | b);
      OP_SLT:          alu_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:         alu_res = {{(W-1){1'b0}}, (a < b)};
      OP_SLL:          alu_res = a << shamt;
      OP_SRL:          alu_res = a >> shamt;
      OP_SRA:          alu_res = $signed(a) >>> shamt;
      OP_MFHI:         alu_res = hi;
      OP_MFLO:         alu_res = lo;
      OP_MTHI, OP_MTLO: alu_res = a;
      OP_MULT:  begin is_mul = 1'b1; is_sgn = 1'b1; end
      OP_MULTU:       is_mul = 1'b1;
      OP_DIV:   begin is_div = 1'b1; is_sgn = 1'b1; end
      OP_DIVU:        is_div = 1'b1;
      default:  alu_res = '1;
    endcase
  end

  // Iterate on magnitudes; signs are reapplied on the final edge.
  assign a_neg = is_sgn && a[W-1];
  assign b_neg = is_sgn && b[W-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // One iteration. MUL: {acc_hi,acc_lo} is partial product over remaining
  // multiplier bits. DIV: acc_hi is the partial remainder, acc_lo shifts the
  // dividend out at the top and the quotient in at the bottom.
  logic [W:0]   mul_sum, div_trial;
  logic [W-1:0] step_hi, step_lo;
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    div_trial = {acc_hi, acc_lo[W-1]} - {1'b0, opnd};
    if (state == MUL) begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], acc_lo[W-1:1]};
    end else if (!div_trial[W]) begin
      step_hi = div_trial[W-1:0];
      step_lo = {acc_lo[W-2:0], 1'b1};
    end else begin
      step_hi = {acc_hi[W-2:0], acc_lo[W-1]};
      step_lo = {acc_lo[W-2:0], 1'b0};
    end
  end

  // Final HI/LO from the last iteration, with sign correction.
  logic [2*W-1:0] prod;
  logic [W-1:0]   fin_hi, fin_lo;
  always_comb begin
    prod = {step_hi, step_lo};
    if (neg_lo) prod = -prod;
    if (state == MUL) begin
      fin_hi = prod[2*W-1:W];
      fin_lo = prod[W-1:0];
    end else if (dbz) begin
      fin_hi = a_save;
      fin_lo = '1;
    end else begin
      fin_hi = neg_hi ? -step_hi : step_hi;
      fin_lo = neg_lo ? -step_lo : step_lo;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && is_mul)      state_nxt = MUL;
        else if (accept && is_div) state_nxt = DIV;
      end
      MUL, DIV: if (last) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hi <= '0; lo <= '0; result_q <= '0; acc_hi <= '0; acc_lo <= '0;
      opnd <= '0; a_save <= '0; cnt <= '0;
      valid_q <= 1'b0; zero_q <= 1'b1; dbz_q <= 1'b0;
      dbz <= 1'b0; neg_hi <= 1'b0; neg_lo <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          dbz_q <= 1'b0;
          cnt   <= '0;
          if (is_mul || is_div) begin
            // Multiplier / dividend goes in acc_lo, the other operand in opnd.
            acc_hi <= '0;
            acc_lo <= a_mag;
            opnd   <= b_mag;
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= a_neg;
            dbz    <= is_div && (b == '0);
            a_save <= a;
          end else begin
            valid_q  <= 1'b1;
            result_q <= alu_res;
            zero_q   <= (alu_res == '0);
            if (bus.i_mode == OP_MTHI) hi <= a;
            if (bus.i_mode == OP_MTLO) lo <= a;
          end
        end
      end else begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        cnt    <= cnt + 1'b1;
        if (last) begin
          hi       <= fin_hi;
          lo       <= fin_lo;
          result_q <= fin_lo;
          zero_q   <= (fin_lo == '0);
          dbz_q    <= dbz;
          valid_q  <= 1'b1;
          cnt      <= '0;
        end
      end
    end
  end
endmodule
